otter_fetch_unit: RTL and testbench
===================================

// Module: otter_fetch_unit
// PURPOSE
//  Instruction-fetch front end for the pipelined OTTER; sits directly upstream of the decode stage.
//  Owns the PC, issues reads on the instruction port of the memory (1-cycle synchronous read),
//  buffers returned words in a small queue, and hands {IR, PC, PC+4} to decode over valid/ready.
//  Branch/jump/trap redirects flush in-flight and queued instructions and restart fetch at the new PC.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC of the first fetch after reset release
//  QDEPTH    2              instruction queue entries (>=2; 2 gives 1 instr/cycle steady state)
// PORTS
//  CLK          in   1   single clock, all state on rising edge
//  RESET_N      in   1   asynchronous, active-low reset
//  REDIRECT     in   1   flush and restart fetch at REDIRECT_PC (1-cycle pulse or held)
//  REDIRECT_PC  in   32  new fetch PC; bits [1:0] ignored (forced 0)
//  IMEM_RD      out  1   instruction read enable (memory port 1 MEM_READ1)
//  IMEM_ADDR    out  32  byte address of the fetch (memory port 1 MEM_ADDR1)
//  IMEM_DATA    in   32  read data, valid the cycle after IMEM_RD=1 (MEM_DOUT1)
//  ID_VALID     out  1   ID_IR/ID_PC/ID_NEXT_PC hold a valid instruction
//  ID_READY     in   1   decode accepts the instruction this cycle
//  ID_IR        out  32  instruction word at queue head
//  ID_PC        out  32  PC of ID_IR
//  ID_NEXT_PC   out  32  ID_PC + 4 (mod 2^32)
// BEHAVIOUR
//  Reset (RESET_N=0): fetch PC=RESET_PC, queue count=0, in-flight=0; IMEM_RD=0, ID_VALID=0,
//   ID_IR/ID_PC/ID_NEXT_PC=0. Reset asserted mid-operation discards everything, no partial state.
//  Issue: IMEM_RD=1 with IMEM_ADDR=fetch PC in cycle t iff !REDIRECT and
//   (count + inflight - pop) < QDEPTH, where pop = ID_VALID & ID_READY. On issue, fetch PC += 4
//   (32-bit wrap, 0xFFFF_FFFC -> 0x0000_0000) and inflight<=1, tagged with the issued PC.
//  Return: in cycle t+1 IMEM_DATA is written into the queue with its PC at the end of t+1;
//   ID_VALID rises in t+2 (issue-to-decode latency 2 cycles). Queue output is registered.
//  Handshake: transfer occurs when ID_VALID & ID_READY; outputs hold stable while ID_VALID=1 and
//   ID_READY=0. ID_VALID never drops without a transfer except on REDIRECT or reset.
//  Queue: circular FIFO, wrap-around pointers mod QDEPTH; simultaneous push and pop allowed,
//   including when full (pop frees the slot the same cycle). Credit rule guarantees no overflow;
//   overflow is a design error (assert in simulation).
//  Redirect (REDIRECT=1 in cycle r): queue cleared and in-flight response dropped at end of r;
//   fetch PC <= {REDIRECT_PC[31:2],2'b00}; IMEM_RD=0 in r; first fetch of new PC in r+1;
//   ID_VALID=0 in r+1, r+2; first new instruction ID_VALID=1 in r+3.
//  Redirect with a simultaneous handshake in r: that transfer completes (decode owns it); all
//   other entries are discarded. Redirect held multiple cycles: last-cycle REDIRECT_PC wins.
//  Redirect has priority over issue and push; reset has priority over everything.
//  States: RUN (issuing per credit), FLUSH (redirect cycle, no issue). FLUSH->RUN unconditionally
//   next cycle unless REDIRECT still high.
//  Throughput: with ID_READY=1 and QDEPTH>=2, one instruction per cycle after the 2-cycle fill.
// TESTING
//  Reset release, RESET_PC=0x100, ID_READY=1 -> IMEM_ADDR 0x100,0x104,... each cycle; ID_VALID
//   first high 2 cycles after first IMEM_RD with ID_PC=0x100, ID_NEXT_PC=0x104, then 1/cycle.
//  ID_READY=0 for 5 cycles mid-stream -> IMEM_RD stops once queue+inflight=QDEPTH; ID outputs
//   frozen; on ID_READY=1 PCs resume in order, none lost or duplicated.
//  REDIRECT pulse to 0x2000 while queue full and 1 in flight -> no stale PC ever presented;
//   IMEM_ADDR=0x2000 next cycle; ID_PC=0x2000 with ID_VALID=1 exactly 3 cycles after pulse.
//  REDIRECT coincident with ID_VALID&ID_READY at PC 0x40 -> 0x40 transferred once; next valid
//   ID_PC equals REDIRECT_PC.
//  REDIRECT_PC=0x0000_3003 -> fetch at 0x0000_3000; redirect to 0xFFFF_FFF8 -> PCs
//   0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (ID_NEXT_PC of 0xFFFF_FFFC is 0x0).
//  Assert RESET_N low while instructions in flight and queued -> IMEM_RD, ID_VALID low
//   immediately (async); after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/otter_fetch_unit_if.sv
// Fetch-unit bus: the instruction-memory read port, the decode-stage valid/ready handoff, and the redirect request.
// The master modport is the fetch unit's view. The slave modport is the surrounding pipeline's view.
interface otter_fetch_unit_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_rd;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_ir;
  logic [31:0] id_pc;
  logic [31:0] id_next_pc;

  modport master (
    input  redirect, redirect_pc, imem_data, id_ready,
    output imem_rd, imem_addr, id_valid, id_ir, id_pc, id_next_pc
  );

  modport slave (
    output redirect, redirect_pc, imem_data, id_ready,
    input  imem_rd, imem_addr, id_valid, id_ir, id_pc, id_next_pc
  );
endinterface

// File: rtl/otter_fetch_unit.sv
// OTTER instruction-fetch front end: owns the PC, issues credit-limited reads to a 1-cycle synchronous
// instruction memory, queues the returned words, and hands {IR, PC, PC+4} to decode over valid/ready.
module otter_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  otter_fetch_unit_if.master     io_fetch
);
  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_inflight_pc;
  logic          r_inflight;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [31:0]   r_q_ir [QDEPTH];
  logic [31:0]   r_q_pc [QDEPTH];

  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic [31:0]   w_credit_use;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_valid      = (r_count != '0);
  assign w_pop        = w_valid & io_fetch.id_ready;
  assign w_push       = r_inflight & ~io_fetch.redirect;
  // Slots the queue will still hold next cycle; a pop this cycle frees its slot immediately.
  assign w_credit_use = 32'(r_count) + 32'(r_inflight) - 32'(w_pop);
  assign w_issue      = (r_state != ST_IDLE) & ~io_fetch.redirect & (w_credit_use < 32'(QDEPTH));

  assign io_fetch.imem_rd    = w_issue;
  assign io_fetch.imem_addr  = r_fetch_pc;
  assign io_fetch.id_valid   = w_valid;
  assign io_fetch.id_ir      = w_valid ? r_q_ir[r_rd_ptr] : '0;
  assign io_fetch.id_pc      = w_valid ? r_q_pc[r_rd_ptr] : '0;
  assign io_fetch.id_next_pc = w_valid ? r_q_pc[r_rd_ptr] + 32'd4 : '0;

  // ST_IDLE holds off issue while in reset and for the cycle after release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= '0;
      r_inflight    <= 1'b0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_state <= io_fetch.redirect ? ST_FLUSH : ST_RUN;
      if (io_fetch.redirect) begin
        r_fetch_pc <= {io_fetch.redirect_pc[31:2], 2'b00};
        r_inflight <= 1'b0;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        r_inflight <= w_issue;
        if (w_issue) begin
          r_fetch_pc    <= r_fetch_pc + 32'd4;
          r_inflight_pc <= r_fetch_pc;
        end
        if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_ir[r_wr_ptr] <= io_fetch.imem_data;
      r_q_pc[r_wr_ptr] <= r_inflight_pc;
    end
  end

  assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(w_push && !w_pop && (r_count == CW'(QDEPTH))));
endmodule

// File: tb/tb_otter_fetch_unit.sv
// Directed bench for otter_fetch_unit: a 1-cycle synchronous instruction memory returns pc ^ KEY,
// and every presented instruction is checked against the expected in-order PC stream.
module tb_otter_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] KEY    = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  otter_fetch_unit_if bus ();

  otter_fetch_unit #(.RESET_PC(RST_PC), .QDEPTH(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_fetch(bus)
  );

  always @(posedge clk) begin
    if (bus.imem_rd) bus.imem_data <= bus.imem_addr ^ KEY;
  end

  int          n_chk = 0;
  int          n_bad = 0;
  int          cyc, first_rd_cyc, first_val_cyc, n_xfer, n_40, n0;
  logic [31:0] exp_fetch, exp_pc, hold_pc, hold_ir;
  logic        hold_prev;
  logic        s_rd, s_valid;
  logic [31:0] s_addr, s_ir, s_pc, s_npc;
  logic [31:0] xq[$];
  logic [31:0] nq[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample the cycle's outputs, score them, advance to next edge.
  task automatic tick(input logic rdy, input logic redir, input logic [31:0] rpc);
    bus.id_ready    = rdy;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    #1;
    s_rd = bus.imem_rd;   s_addr = bus.imem_addr;
    s_valid = bus.id_valid; s_ir = bus.id_ir; s_pc = bus.id_pc; s_npc = bus.id_next_pc;
    if (s_rd) begin
      check_val("fetch_addr", s_addr, exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (hold_prev) begin
      check_val("hold_valid", {31'd0, s_valid}, 32'd1);
      check_val("hold_pc", s_pc, hold_pc);
      check_val("hold_ir", s_ir, hold_ir);
    end
    if (s_valid) begin
      check_val("id_pc", s_pc, exp_pc);
      check_val("id_ir", s_ir, exp_pc ^ KEY);
      check_val("id_next_pc", s_npc, exp_pc + 32'd4);
      if (first_val_cyc < 0) first_val_cyc = cyc;
      if (rdy) begin
        $display("xfer pc=%h ir=%h next=%h", s_pc, s_ir, s_npc);
        xq.push_back(s_pc);
        nq.push_back(s_npc);
        if (s_pc == 32'h40) n_40++;
        n_xfer++;
        exp_pc = exp_pc + 32'd4;
      end
    end
    hold_prev = s_valid & ~rdy & ~redir;
    hold_pc   = s_pc;
    hold_ir   = s_ir;
    if (redir) begin
      check_val("rd_in_redirect", {31'd0, s_rd}, 32'd0);
      exp_pc    = {rpc[31:2], 2'b00};
      exp_fetch = exp_pc;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic restart_model();
    exp_fetch = RST_PC; exp_pc = RST_PC; hold_prev = 1'b0;
    first_rd_cyc = -1; first_val_cyc = -1; cyc = 0;
    xq.delete(); nq.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.id_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    n_xfer = 0; n_40 = 0;
    restart_model();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_imem_rd", {31'd0, bus.imem_rd}, 32'd0);
    check_val("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
    check_val("rst_id_ir", bus.id_ir, 32'd0);
    check_val("rst_id_pc", bus.id_pc, 32'd0);
    check_val("rst_id_next_pc", bus.id_next_pc, 32'd0);

    // Reset release and steady streaming
    rst_n = 1'b1;
    repeat (12) tick(1'b1, 1'b0, '0);
    check_val("fetch_started", {31'd0, first_rd_cyc >= 0}, 32'd1);
    check_val("fill_latency", 32'(first_val_cyc - first_rd_cyc), 32'd2);
    check_val("first_pc", xq[0], RST_PC);
    check_val("first_next_pc", nq[0], RST_PC + 32'd4);
    n0 = n_xfer;
    repeat (8) tick(1'b1, 1'b0, '0);
    check_val("throughput", 32'(n_xfer - n0), 32'd8);

    // Decode stall: credit exhausted, outputs frozen, then resume in order
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, '0);
      check_val("stall_no_rd", {31'd0, s_rd}, 32'd0);
    end
    n0 = n_xfer;
    repeat (6) tick(1'b1, 1'b0, '0);
    check_val("resume_xfers", 32'(n_xfer - n0), 32'd6);

    // Redirect with a full queue
    repeat (3) tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b1, 32'h0000_2000);
    tick(1'b1, 1'b0, '0);
    check_val("redir_rd", {31'd0, s_rd}, 32'd1);
    check_val("redir_addr", s_addr, 32'h0000_2000);
    check_val("redir_v1", {31'd0, s_valid}, 32'd0);
    tick(1'b1, 1'b0, '0);
    check_val("redir_v2", {31'd0, s_valid}, 32'd0);
    tick(1'b1, 1'b0, '0);
    check_val("redir_v3", {31'd0, s_valid}, 32'd1);
    check_val("redir_pc", s_pc, 32'h0000_2000);

    // Redirect coincident with a handshake at 0x40
    tick(1'b1, 1'b1, 32'h0000_0040);
    repeat (2) tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b1, 32'h0000_0500);
    check_val("hs_valid", {31'd0, s_valid}, 32'd1);
    check_val("hs_pc", s_pc, 32'h0000_0040);
    repeat (2) tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    check_val("hs_next_valid", {31'd0, s_valid}, 32'd1);
    check_val("hs_next_pc", s_pc, 32'h0000_0500);
    check_val("xfer_40_once", 32'(n_40), 32'd1);

    // Misaligned redirect target and PC wrap
    tick(1'b1, 1'b1, 32'h0000_3003);
    tick(1'b1, 1'b0, '0);
    check_val("align_rd", {31'd0, s_rd}, 32'd1);
    check_val("align_addr", s_addr, 32'h0000_3000);
    tick(1'b1, 1'b1, 32'hFFFF_FFF8);
    xq.delete(); nq.delete();
    repeat (6) tick(1'b1, 1'b0, '0);
    check_val("wrap_cnt", 32'(xq.size()), 32'd4);
    check_val("wrap_pc0", xq[0], 32'hFFFF_FFF8);
    check_val("wrap_pc1", xq[1], 32'hFFFF_FFFC);
    check_val("wrap_npc1", nq[1], 32'h0000_0000);
    check_val("wrap_pc2", xq[2], 32'h0000_0000);

    // Asynchronous reset with work queued and in flight
    tick(1'b0, 1'b0, '0);
    rst_n = 1'b0;
    #1;
    check_val("arst_imem_rd", {31'd0, bus.imem_rd}, 32'd0);
    check_val("arst_id_valid", {31'd0, bus.id_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    restart_model();
    rst_n = 1'b1;
    repeat (8) tick(1'b1, 1'b0, '0);
    check_val("rerun_fill_latency", 32'(first_val_cyc - first_rd_cyc), 32'd2);
    check_val("rerun_first_pc", xq[0], RST_PC);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
